// File: rtl/pio_out_pkg.sv
// pio_out_pkg: register map, STATUS bit positions and pulse state type for avalon_pio_out_pulse.
package pio_out_pkg;
  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_OUTSET     = 3'd2;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd4;
  localparam logic [2:0] ADDR_PULSE_MASK = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;
  localparam int ST_BUSY   = 0;
  localparam int ST_ABORT  = 1;
  localparam int ST_DONE   = 2;
  localparam int ST_IRQ_EN = 3;
  localparam int ST_CNT    = 16;
  typedef enum logic {IDLE, ACTIVE} pulse_state_t;
endpackage

// File: rtl/pio_pulse_timer.sv
// pio_pulse_timer: pulse FSM with down counter; busy for exactly len clocks after start.
module pio_pulse_timer
  import pio_out_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] cnt
);
  pulse_state_t state, state_n;
  logic [CNT_W-1:0] cnt_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    done_pulse = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = ACTIVE;
        cnt_n   = len;
      end
    end else if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state_n    = IDLE;
        done_pulse = 1'b1;
      end
    end
  end
  assign busy = (state == ACTIVE);
endmodule

// File: rtl/avalon_pio_out_pulse.sv
// avalon_pio_out_pulse: Avalon-MM output PIO with set/clear and timed bit-inversion pulses.
// Define PIO_PULSE_IRQ_EN to add the irq port and the STATUS irq_en bit.
module avalon_pio_out_pulse
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
`ifdef PIO_PULSE_IRQ_EN
  ,
  output logic             irq
`endif
);
  logic [WIDTH-1:0] data_reg, mask_reg, wd;
  logic [CNT_W-1:0] len_reg, cnt;
  logic             done, done_pulse, wr, st_wr, mask_wr, start, abort;
  logic [31:0]      rd;
  logic             unused;
  assign unused  = ^writedata;
  assign wd      = writedata[WIDTH-1:0];
  assign wr      = chipselect & ~write_n;
  assign st_wr   = wr & (address == ADDR_STATUS);
  assign mask_wr = wr & (address == ADDR_PULSE_MASK);
  assign start   = mask_wr & ~busy & (|wd) & (|len_reg);
  assign abort   = st_wr & writedata[ST_ABORT];
  pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .len       (len_reg),
    .busy      (busy),
    .done_pulse(done_pulse),
    .cnt       (cnt)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
      mask_reg <= '0;
      len_reg  <= '0;
      done     <= 1'b0;
      readdata <= '0;
    end else begin
      data_reg <= !wr                         ? data_reg :
                  address == ADDR_DATA        ? wd :
                  address == ADDR_OUTSET      ? data_reg | wd :
                  address == ADDR_OUTCLEAR    ? data_reg & ~wd : data_reg;
      len_reg  <= wr && address == ADDR_PULSE_LEN ? writedata[CNT_W-1:0] : len_reg;
      mask_reg <= mask_wr && !busy ? wd : mask_reg;
      done     <= done_pulse | (done & ~(st_wr & writedata[ST_DONE]));
      readdata <= rd;
    end
`ifdef PIO_PULSE_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irq_en <= 1'b0;
    else          irq_en <= st_wr ? writedata[ST_IRQ_EN] : irq_en;
  assign irq = done & irq_en;
`endif
  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA:       rd[WIDTH-1:0] = data_reg;
      ADDR_PULSE_LEN:  rd[CNT_W-1:0] = len_reg;
      ADDR_PULSE_MASK: rd[WIDTH-1:0] = mask_reg;
      ADDR_STATUS: begin
        rd[ST_BUSY]          = busy;
        rd[ST_DONE]          = done;
        rd[ST_CNT +: CNT_W]  = cnt;
`ifdef PIO_PULSE_IRQ_EN
        rd[ST_IRQ_EN]        = irq_en;
`endif
      end
      default: ;
    endcase
  end
  assign out_port = data_reg ^ (busy ? mask_reg : '0);
endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// tb_avalon_pio_out_pulse: vector table, directed corner sequences and random traffic vs a behavioural model.
module tb_avalon_pio_out_pulse;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;
`ifdef PIO_PULSE_IRQ_EN
  logic        irq;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  avalon_pio_out_pulse #(.WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .busy      (busy)
`ifdef PIO_PULSE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (act timeout, req finish)");
    $fatal(1, "watchdog");
  end

  // Reference state: a pulse is simply "m_rem clocks of inversion left".
  int unsigned m_data, m_mask, m_len, m_rem;
  bit          m_done, m_irqen;
  logic [31:0] exp_rd;

  task automatic model_reset();
    m_data = 32'hA5; m_mask = 0; m_len = 0; m_rem = 0; m_done = 0; m_irqen = 0;
  endtask

  task automatic model_step(bit cs, bit wn, int addr, logic [31:0] wd);
    bit wr = cs && !wn;
    bit fin = 0;
    bit was_busy = (m_rem > 0);
    logic [31:0] r = 0;
    case (addr)
      0: r = m_data;
      4: r = m_len;
      5: r = m_mask;
      6: begin
        r = (m_rem << 16) | (32'(m_done) << 2) | 32'(was_busy);
`ifdef PIO_PULSE_IRQ_EN
        r = r | (32'(m_irqen) << 3);
`endif
      end
      default: r = 0;
    endcase
    exp_rd = r;
    if (was_busy) begin
      if (wr && addr == 6 && wd[1]) m_rem = 0;
      else begin
        fin = (m_rem == 1);
        m_rem = m_rem - 1;
      end
    end else if (wr && addr == 5 && (wd & 255) != 0 && m_len != 0) m_rem = m_len;
    if (wr && addr == 5 && !was_busy) m_mask = wd & 255;
    if (wr) begin
      if (addr == 0) m_data = wd & 255;
      if (addr == 2) m_data = m_data | (wd & 255);
      if (addr == 3) m_data = m_data & ~wd & 255;
      if (addr == 4) m_len = wd & 16'hFFFF;
`ifdef PIO_PULSE_IRQ_EN
      if (addr == 6) m_irqen = wd[3];
`endif
    end
    if (fin) m_done = 1;
    else if (wr && addr == 6 && wd[2]) m_done = 0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(bit cs, bit wn, int addr, logic [31:0] wd);
    chipselect = cs; write_n = wn; address = addr[2:0]; writedata = wd;
    @(posedge clk);
    model_step(cs, wn, addr, wd);
    @(negedge clk);
    chk("out_port", 32'(out_port), m_data ^ (m_rem > 0 ? m_mask : 0));
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("readdata", readdata, exp_rd);
`ifdef PIO_PULSE_IRQ_EN
    chk("irq", 32'(irq), 32'(m_done & m_irqen));
`endif
  endtask

  task automatic wr(int addr, logic [31:0] d); cyc(1, 0, addr, d); endtask
  task automatic idle(int addr); cyc(0, 1, addr, 0); endtask

  typedef struct {
    bit          cs;
    bit          wn;
    int          addr;
    logic [31:0] wd;
    logic [7:0]  out;
    logic        bsy;
    logic [31:0] rd;
  } vec_t;
  vec_t tv[10];

  initial begin
    int n;
    tv[0] = '{0, 1, 0, 32'h0,        8'hA5, 0, 32'hA5};
    tv[1] = '{1, 0, 0, 32'hFFFF_FF3C, 8'h3C, 0, 32'hA5};
    tv[2] = '{1, 0, 2, 32'h81,       8'hBD, 0, 32'h0};
    tv[3] = '{1, 0, 3, 32'h04,       8'hB9, 0, 32'h0};
    tv[4] = '{1, 1, 1, 32'h0,        8'hB9, 0, 32'h0};
    tv[5] = '{1, 0, 7, 32'hFF,       8'hB9, 0, 32'h0};
    tv[6] = '{1, 0, 1, 32'hFF,       8'hB9, 0, 32'h0};
    tv[7] = '{0, 1, 0, 32'h0,        8'hB9, 0, 32'hB9};
    tv[8] = '{0, 1, 4, 32'h0,        8'hB9, 0, 32'h0};
    tv[9] = '{0, 1, 6, 32'h0,        8'hB9, 0, 32'h0};
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out", 32'(out_port), 32'hA5);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", readdata, 0);
    reset_n = 1'b1;
    foreach (tv[i]) begin
      cyc(tv[i].cs, tv[i].wn, tv[i].addr, tv[i].wd);
      chk("tv_out", 32'(out_port), 32'(tv[i].out));
      chk("tv_busy", 32'(busy), 32'(tv[i].bsy));
      chk("tv_rd", readdata, tv[i].rd);
    end
    // 5-clock pulse on bit 0
    wr(4, 5); wr(0, 0); wr(5, 1);
    chk("p5_out", 32'(out_port), 1);
    n = 1;
    while (busy && n < 100) begin idle(6); if (busy) n++; end
    chk("p5_len", n, 5);
    chk("p5_out_after", 32'(out_port), 0);
    idle(6);
    chk("p5_done", readdata, 32'h4);
    // ignored mask, live data update, abort
    wr(6, 4); wr(4, 10); wr(5, 1); idle(0); idle(0);
    wr(5, 8'hFF);
    wr(0, 8'hF0);
    chk("act_data", 32'(out_port), 32'hF1);
    idle(0);
    wr(6, 2);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out", 32'(out_port), 32'hF0);
    idle(6);
    chk("abort_status", readdata, 0);
    idle(5);
    chk("mask_kept", readdata, 1);
    // degenerate triggers
    wr(4, 0); wr(5, 3);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_out", 32'(out_port), 32'hF0);
    wr(4, 3); wr(5, 32'hFFFF_FF00);
    chk("mask0_busy", 32'(busy), 0);
    chk("mask0_out", 32'(out_port), 32'hF0);
    // maximum length
    wr(4, 32'hFFFF); wr(5, 1);
    idle(6);
    chk("max_remaining", readdata, 32'hFFFF_0001);
    n = 2;
    while (busy && n < 70000) begin idle(6); if (busy) n++; end
    chk("max_len", n, 65535);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      int a = $urandom_range(0, 7);
      logic [31:0] d = $urandom;
      if (a == 4) d = $urandom_range(0, 12);
      if (a == 6) d = d & ($urandom_range(0, 9) == 0 ? 32'hF : 32'hD);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d);
    end
    wr(6, 2); wr(6, 4);
    // completion coinciding with done clear
    wr(0, 0); wr(4, 2); wr(5, 1); idle(0);
    wr(6, 4);
    chk("set_wins_busy", 32'(busy), 0);
    idle(6);
    chk("set_wins_done", readdata, 32'h4);
    // irq enable bit
    wr(6, 8);
    idle(6);
`ifdef PIO_PULSE_IRQ_EN
    chk("irq_en_rd", readdata, 32'hC);
    chk("irq_on", 32'(irq), 1);
    wr(6, 32'hC);
    chk("irq_off", 32'(irq), 0);
`else
    chk("bit3_rd", readdata, 32'h4);
`endif
    // asynchronous reset mid-pulse
    wr(4, 20); wr(5, 3);
    reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_port), 32'hA5);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rd", readdata, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(0);
    chk("arst_data", readdata, 32'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
